// File: rtl/fetch_unit.sv
// Program counter + fetch stage: drives ROM address, registers returned word into the IR.
// Latency: ROM word at prog_ctr appears on ir_out one edge later; taken jumps cost a 1-cycle bubble.
// Backpressure: stall holds PC, IR, valid and counter; jump enables are ignored while stalled.
module fetch_unit #(
   parameter int             D         = 12,
   parameter int             W         = 9,
   parameter logic [W-1:0]   HALT_CODE = '1,
   parameter int             CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stall,
   input  logic             abs_jump_en,
   input  logic             rel_jump_en,
   input  logic [D-1:0]     target,
   input  logic [W-1:0]     mach_code,
   output logic [D-1:0]     prog_ctr,
   output logic [W-1:0]     ir_out,
   output logic [D-1:0]     ir_pc,
   output logic             ir_valid,
   output logic             done,
   output logic [CNT_W-1:0] fetch_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic             jump_taken;
   logic             is_halt;
   logic [D-1:0]     jump_pc;
   logic [CNT_W-1:0] cnt_inc;

   // Jump decode: only a real IR word may redirect; absolute wins over relative.
   always_comb begin
      jump_taken = ir_valid & (abs_jump_en | rel_jump_en);
      jump_pc    = abs_jump_en ? target : (ir_pc + target);
      is_halt    = (mach_code == HALT_CODE);
      cnt_inc    = (fetch_cnt == '1) ? fetch_cnt : (fetch_cnt + 1'b1);
   end

   // Next-state logic: a halt only ends the run when it is not on the squashed wrong path.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (!stall && !jump_taken && is_halt) state_nxt = DONE;
         DONE:    if (start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // State register and fetch datapath.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         prog_ctr  <= '0;
         ir_out    <= '0;
         ir_pc     <= '0;
         ir_valid  <= 1'b0;
         done      <= 1'b0;
         fetch_cnt <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               ir_valid <= 1'b0;
               if (start) begin
                  prog_ctr  <= '0;
                  fetch_cnt <= '0;
               end
            end
            RUN: begin
               if (!stall) begin
                  ir_out <= mach_code;
                  ir_pc  <= prog_ctr;
                  if (jump_taken) begin
                     // Word at prog_ctr was fetched on the wrong path: squash it.
                     prog_ctr <= jump_pc;
                     ir_valid <= 1'b0;
                  end else begin
                     ir_valid  <= 1'b1;
                     fetch_cnt <= cnt_inc;
                     if (is_halt) done <= 1'b1;
                     else         prog_ctr <= prog_ctr + 1'b1;
                  end
               end
            end
            DONE: begin
               ir_valid <= 1'b0;
               if (start) begin
                  prog_ctr  <= '0;
                  done      <= 1'b0;
                  fetch_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural ROM.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: stall is driven directly by the stimulus tasks.
module tb_fetch_unit;

   localparam logic [8:0] HALT = 9'h1FF;

   logic        clk = 1'b0;
   logic        reset, start, stall, abs_jump_en, rel_jump_en;
   logic [11:0] target;
   logic [8:0]  mach_code;
   logic [11:0] prog_ctr, ir_pc;
   logic [8:0]  ir_out;
   logic        ir_valid, done;
   logic [15:0] fetch_cnt;

   logic [8:0]  rom [0:4095];
   int          tests  = 0;
   int          failed = 0;

   assign mach_code = rom[prog_ctr];

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall),
      .abs_jump_en(abs_jump_en), .rel_jump_en(rel_jump_en), .target(target),
      .mach_code(mach_code), .prog_ctr(prog_ctr), .ir_out(ir_out), .ir_pc(ir_pc),
      .ir_valid(ir_valid), .done(done), .fetch_cnt(fetch_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset, then a one-cycle start pulse: afterwards RUN with prog_ctr=0.
   task automatic restart();
      reset = 1'b1; start = 1'b0; stall = 1'b0;
      abs_jump_en = 1'b0; rel_jump_en = 1'b0; target = '0;
      step();
      reset = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; stall = 1'b0;
      abs_jump_en = 1'b0; rel_jump_en = 1'b0; target = '0;
      step(); step();
      tests++;
      if ({prog_ctr, ir_out, ir_pc, ir_valid, done, fetch_cnt} !== 52'd0) begin
         failed++;
         $display("FAIL reset_outputs pc=%0h ir=%0h ir_pc=%0h vld=%0b done=%0b cnt=%0d exp all 0",
                  prog_ctr, ir_out, ir_pc, ir_valid, done, fetch_cnt);
      end
      reset = 1'b0;
      step();
      tests++;
      if ({prog_ctr, ir_valid, done} !== 14'd0) begin
         failed++;
         $display("FAIL idle_no_fetch pc=%0h vld=%0b done=%0b exp 0 0 0", prog_ctr, ir_valid, done);
      end
   endtask

   task automatic test_basic_halt();
      rom[4] = HALT;
      restart();
      tests++;
      if ({prog_ctr, ir_valid, done, fetch_cnt} !== 30'd0) begin
         failed++;
         $display("FAIL start_state pc=%0h vld=%0b done=%0b cnt=%0d exp 0", prog_ctr, ir_valid, done, fetch_cnt);
      end
      for (int k = 0; k < 4; k++) begin
         step();
         tests++;
         if (prog_ctr !== 12'(k + 1) || ir_pc !== 12'(k) || ir_out !== rom[k] ||
             ir_valid !== 1'b1 || done !== 1'b0 || fetch_cnt !== 16'(k + 1)) begin
            failed++;
            $display("FAIL basic_fetch%0d pc=%0h ir_pc=%0h ir=%0h vld=%0b done=%0b cnt=%0d exp pc=%0h ir_pc=%0h ir=%0h 1 0 cnt=%0d",
                     k, prog_ctr, ir_pc, ir_out, ir_valid, done, fetch_cnt, k + 1, k, rom[k], k + 1);
         end
      end
      step();
      tests++;
      if (ir_out !== HALT || ir_pc !== 12'd4 || prog_ctr !== 12'd4 || ir_valid !== 1'b1 ||
          done !== 1'b1 || fetch_cnt !== 16'd5) begin
         failed++;
         $display("FAIL halt_load ir=%0h ir_pc=%0h pc=%0h vld=%0b done=%0b cnt=%0d exp 1ff 4 4 1 1 5",
                  ir_out, ir_pc, prog_ctr, ir_valid, done, fetch_cnt);
      end
      step(); step(); step();
      tests++;
      if (ir_out !== HALT || prog_ctr !== 12'd4 || ir_valid !== 1'b0 || done !== 1'b1 ||
          fetch_cnt !== 16'd5) begin
         failed++;
         $display("FAIL done_frozen ir=%0h pc=%0h vld=%0b done=%0b cnt=%0d exp 1ff 4 0 1 5",
                  ir_out, prog_ctr, ir_valid, done, fetch_cnt);
      end
      // start in DONE restarts at 0 (no reset in between).
      start = 1'b1;
      step();
      start = 1'b0;
      tests++;
      if (prog_ctr !== 12'd0 || done !== 1'b0 || fetch_cnt !== 16'd0 || ir_valid !== 1'b0) begin
         failed++;
         $display("FAIL done_restart pc=%0h done=%0b cnt=%0d vld=%0b exp 0 0 0 0", prog_ctr, done, fetch_cnt, ir_valid);
      end
      step();
      tests++;
      if (ir_pc !== 12'd0 || ir_valid !== 1'b1 || prog_ctr !== 12'd1 || fetch_cnt !== 16'd1) begin
         failed++;
         $display("FAIL restart_fetch ir_pc=%0h vld=%0b pc=%0h cnt=%0d exp 0 1 1 1", ir_pc, ir_valid, prog_ctr, fetch_cnt);
      end
      rom[4] = 9'h004;
   endtask

   task automatic test_jumps();
      restart();
      step(); step(); step();              // ir_pc=2, prog_ctr=3, cnt=3
      abs_jump_en = 1'b1; target = 12'd10;
      step();
      abs_jump_en = 1'b0;
      tests++;
      if (ir_valid !== 1'b0 || prog_ctr !== 12'd10 || ir_pc !== 12'd3 || fetch_cnt !== 16'd3) begin
         failed++;
         $display("FAIL abs_bubble vld=%0b pc=%0h ir_pc=%0h cnt=%0d exp 0 a 3 3", ir_valid, prog_ctr, ir_pc, fetch_cnt);
      end
      step();
      tests++;
      if (ir_pc !== 12'd10 || ir_out !== rom[10] || ir_valid !== 1'b1 || prog_ctr !== 12'd11 || fetch_cnt !== 16'd4) begin
         failed++;
         $display("FAIL abs_target ir_pc=%0h ir=%0h vld=%0b pc=%0h cnt=%0d exp a %0h 1 b 4",
                  ir_pc, ir_out, ir_valid, prog_ctr, fetch_cnt, rom[10]);
      end
      abs_jump_en = 1'b1; target = 12'd5;
      step();
      abs_jump_en = 1'b0;
      step();                              // ir_pc=5 valid
      rel_jump_en = 1'b1; target = 12'hFFD;
      step();
      rel_jump_en = 1'b0;
      tests++;
      if (prog_ctr !== 12'd2 || ir_valid !== 1'b0) begin
         failed++;
         $display("FAIL rel_jump pc=%0h vld=%0b exp 2 0", prog_ctr, ir_valid);
      end
      step();
      tests++;
      if (ir_pc !== 12'd2 || ir_valid !== 1'b1 || prog_ctr !== 12'd3 || fetch_cnt !== 16'd6) begin
         failed++;
         $display("FAIL rel_target ir_pc=%0h vld=%0b pc=%0h cnt=%0d exp 2 1 3 6", ir_pc, ir_valid, prog_ctr, fetch_cnt);
      end
      // Both enables: absolute wins.
      abs_jump_en = 1'b1; rel_jump_en = 1'b1; target = 12'hFFF;
      step();
      abs_jump_en = 1'b0; rel_jump_en = 1'b0;
      tests++;
      if (prog_ctr !== 12'hFFF) begin
         failed++;
         $display("FAIL abs_priority pc=%0h exp fff", prog_ctr);
      end
      step();
      tests++;
      if (ir_pc !== 12'hFFF || prog_ctr !== 12'd0 || ir_valid !== 1'b1) begin
         failed++;
         $display("FAIL pc_wrap ir_pc=%0h pc=%0h vld=%0b exp fff 0 1", ir_pc, prog_ctr, ir_valid);
      end
   endtask

   task automatic test_stall();
      restart();
      step(); step(); step();              // ir_pc=2, prog_ctr=3, cnt=3
      stall = 1'b1; abs_jump_en = 1'b1; target = 12'd20;
      for (int k = 0; k < 3; k++) begin
         step();
         tests++;
         if (prog_ctr !== 12'd3 || ir_pc !== 12'd2 || ir_out !== rom[2] || ir_valid !== 1'b1 ||
             done !== 1'b0 || fetch_cnt !== 16'd3) begin
            failed++;
            $display("FAIL stall_hold%0d pc=%0h ir_pc=%0h ir=%0h vld=%0b cnt=%0d exp 3 2 %0h 1 3",
                     k, prog_ctr, ir_pc, ir_out, ir_valid, fetch_cnt, rom[2]);
         end
      end
      stall = 1'b0;
      step();
      tests++;
      if (prog_ctr !== 12'd20 || ir_valid !== 1'b0 || ir_pc !== 12'd3 || fetch_cnt !== 16'd3) begin
         failed++;
         $display("FAIL stall_jump pc=%0h vld=%0b ir_pc=%0h cnt=%0d exp 14 0 3 3", prog_ctr, ir_valid, ir_pc, fetch_cnt);
      end
      // abs_jump_en still high but ir_valid=0: must be ignored.
      step();
      abs_jump_en = 1'b0;
      tests++;
      if (prog_ctr !== 12'd21 || ir_pc !== 12'd20 || ir_valid !== 1'b1 || fetch_cnt !== 16'd4) begin
         failed++;
         $display("FAIL jump_once pc=%0h ir_pc=%0h vld=%0b cnt=%0d exp 15 14 1 4", prog_ctr, ir_pc, ir_valid, fetch_cnt);
      end
   endtask

   task automatic test_halt_squash();
      rom[3] = HALT;
      restart();
      step(); step(); step();              // prog_ctr=3 presenting HALT, ir_pc=2
      abs_jump_en = 1'b1; target = 12'd8;
      step();
      abs_jump_en = 1'b0;
      tests++;
      if (ir_out !== HALT || ir_valid !== 1'b0 || done !== 1'b0 || prog_ctr !== 12'd8 || fetch_cnt !== 16'd3) begin
         failed++;
         $display("FAIL halt_squash ir=%0h vld=%0b done=%0b pc=%0h cnt=%0d exp 1ff 0 0 8 3",
                  ir_out, ir_valid, done, prog_ctr, fetch_cnt);
      end
      step();
      tests++;
      if (ir_pc !== 12'd8 || ir_valid !== 1'b1 || done !== 1'b0 || prog_ctr !== 12'd9 || fetch_cnt !== 16'd4) begin
         failed++;
         $display("FAIL after_squash ir_pc=%0h vld=%0b done=%0b pc=%0h cnt=%0d exp 8 1 0 9 4",
                  ir_pc, ir_valid, done, prog_ctr, fetch_cnt);
      end
      rom[3] = 9'h003;
   endtask

   task automatic test_reset_midrun();
      restart();
      for (int k = 0; k < 7; k++) step();
      tests++;
      if (prog_ctr !== 12'd7) begin
         failed++;
         $display("FAIL midrun_pc pc=%0h exp 7", prog_ctr);
      end
      reset = 1'b1; stall = 1'b1; start = 1'b1; abs_jump_en = 1'b1; target = 12'd30;
      step();
      tests++;
      if ({prog_ctr, ir_out, ir_pc, ir_valid, done, fetch_cnt} !== 52'd0) begin
         failed++;
         $display("FAIL midrun_reset pc=%0h ir=%0h ir_pc=%0h vld=%0b done=%0b cnt=%0d exp all 0",
                  prog_ctr, ir_out, ir_pc, ir_valid, done, fetch_cnt);
      end
      reset = 1'b0; stall = 1'b0; start = 1'b0; abs_jump_en = 1'b0;
      step(); step();
      tests++;
      if ({prog_ctr, ir_out, ir_valid, done, fetch_cnt} !== 40'd0) begin
         failed++;
         $display("FAIL idle_after_reset pc=%0h ir=%0h vld=%0b done=%0b cnt=%0d exp all 0",
                  prog_ctr, ir_out, ir_valid, done, fetch_cnt);
      end
   endtask

   task automatic test_saturation();
      restart();
      for (int k = 0; k < 65540; k++) step();
      tests++;
      if (fetch_cnt !== 16'hFFFF || ir_valid !== 1'b1) begin
         failed++;
         $display("FAIL cnt_saturate cnt=%0h vld=%0b exp ffff 1", fetch_cnt, ir_valid);
      end
      tests++;
      if (prog_ctr !== 12'(65540 % 4096)) begin
         failed++;
         $display("FAIL long_run_pc pc=%0h exp %0h", prog_ctr, 65540 % 4096);
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) rom[i] = 9'(i & 8'hFF);
      test_reset();
      test_basic_halt();
      test_jumps();
      test_stall();
      test_halt_squash();
      test_reset_midrun();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
